// File: rtl/mux_n1_seq_pkg.sv
// Shared types and width helpers for the sequential N:1 multiplexer.
package mux_n1_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWITCH,
        S_HOLD,
        S_SCAN
    } state_e;

    // The dwell limit is at most 255, so an 8-bit counter always suffices.
    localparam int DWELL_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int n_ch);
        return (clog2(n_ch) > 1) ? clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/mux_n1_seq_dwell_cnt.sv
// Dwell timer: counts enabled cycles and pulses o_EXPIRE on the last one.
module dwell_cnt
    import mux_n1_seq_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_LOAD,
    input  logic i_EN,
    output logic o_EXPIRE
);

    logic [DWELL_W-1:0] cnt_q;

    assign o_EXPIRE = i_EN && (cnt_q == DWELL_W'(DWELL - 1));

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt_q <= '0;
        end else if (i_LOAD || o_EXPIRE) begin
            cnt_q <= '0;
        end else if (i_EN) begin
            cnt_q <= cnt_q + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/mux_n1_seq.sv
// Sequential N:1 channel multiplexer with manual select and round-robin scan.
// Output data is registered; every channel change inserts one blanking cycle.
module mux_n1_seq
    import mux_n1_seq_pkg::*;
#(
    parameter int  N_CH  = 4,
    parameter int  WIDTH = 1,
    parameter int  DWELL = 4,
    localparam int SELW  = sel_width(N_CH)
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [N_CH*WIDTH-1:0] i_DATA,
    input  logic [SELW-1:0]       i_SEL,
    input  logic                  i_SEL_VALID,
    output logic                  o_SEL_READY,
    input  logic                  i_SCAN_EN,
    output logic [WIDTH-1:0]      o_OUT,
    output logic                  o_OUT_VALID,
    output logic [SELW-1:0]       o_CUR_SEL,
    output logic                  o_ERR
);

    state_e           state_q;
    logic [SELW-1:0]  cur_sel_q;
    logic [SELW-1:0]  next_sel;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] chan_data;
    logic             valid_q;
    logic             ready_q;
    logic             err_q;
    logic             sel_fire;
    logic             sel_in_range;
    logic             dwell_expire;

    // Scan enable vetoes ready combinationally so a same-cycle select never transfers.
    assign o_SEL_READY  = ready_q & ~i_SCAN_EN;
    assign sel_fire     = i_SEL_VALID & o_SEL_READY;
    assign sel_in_range = int'(i_SEL) < N_CH;
    assign next_sel     = (int'(cur_sel_q) == N_CH - 1) ? '0 : cur_sel_q + SELW'(1);
    assign chan_data    = i_DATA[cur_sel_q*WIDTH +: WIDTH];

    assign o_OUT       = out_q;
    assign o_OUT_VALID = valid_q;
    assign o_CUR_SEL   = cur_sel_q;
    assign o_ERR       = err_q;

    dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_LOAD   (state_q == S_SWITCH),
        .i_EN     (state_q == S_SCAN),
        .o_EXPIRE (dwell_expire)
    );

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= S_IDLE;
            cur_sel_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= sel_fire & ~sel_in_range;
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (i_SCAN_EN) begin
                        state_q   <= S_SWITCH;
                        cur_sel_q <= '0;
                        valid_q   <= 1'b0;
                        ready_q   <= 1'b0;
                    end else if (sel_fire && sel_in_range) begin
                        state_q   <= S_SWITCH;
                        cur_sel_q <= i_SEL;
                        valid_q   <= 1'b0;
                        ready_q   <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                        if (state_q == S_HOLD) out_q <= chan_data;
                    end
                end
                S_SWITCH: begin
                    state_q <= i_SCAN_EN ? S_SCAN : S_HOLD;
                    out_q   <= chan_data;
                    valid_q <= 1'b1;
                    ready_q <= ~i_SCAN_EN;
                end
                S_SCAN: begin
                    if (!i_SCAN_EN) begin
                        state_q <= S_HOLD;
                        ready_q <= 1'b1;
                        out_q   <= chan_data;
                    end else if (dwell_expire) begin
                        state_q   <= S_SWITCH;
                        cur_sel_q <= next_sel;
                        valid_q   <= 1'b0;
                    end else begin
                        out_q <= chan_data;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
